// File: rtl/vga_axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axil_pkg
//  Description : Shared AXI-Lite types, response codes and arbiter FSM states
//                for the VGA register path.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_axil_pkg;

   typedef logic [31:0] axil_addr_t;
   typedef logic [31:0] axil_data_t;
   typedef logic [1:0]  axil_resp_t;

   localparam axil_resp_t AXIL_RESP_OKAY   = 2'b00;
   localparam axil_resp_t AXIL_RESP_EXOKAY = 2'b01;
   localparam axil_resp_t AXIL_RESP_SLVERR = 2'b10;
   localparam axil_resp_t AXIL_RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4
   } axil_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/vga_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_rr_arbiter
//  Description : Combinational round-robin pick: first requester at or after
//                ptr, searching circularly.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             req [N],
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   always_comb begin
      int                k;
      logic [IDX_W-1:0]  idx;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      k         = 0;
      idx       = '0;
      // Walk from farthest to nearest so the nearest requester is written last
      for (int off = N - 1; off >= 0; off--) begin
         k = int'(ptr) + off;
         if (k >= N) begin
            k = k - N;
         end
         idx = IDX_W'(k);
         if (req[idx]) begin
            gnt_idx   = idx;
            gnt_valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/vga_axil_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axil_arbiter
//  Description : Round-robin AXI-Lite arbiter sharing one downstream slave
//                between NUM_MASTERS masters, one transaction at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_axil_arbiter #(
   parameter int  NUM_MASTERS = 2,
   parameter type axil_addr_t = vga_axil_pkg::axil_addr_t,
   parameter type axil_data_t = vga_axil_pkg::axil_data_t,
   localparam int STRB_W      = $bits(axil_data_t) / 8
) (
   input  logic              clk,
   input  logic              arst_n,

   input  axil_addr_t        s_araddr  [NUM_MASTERS],
   input  logic              s_arvalid [NUM_MASTERS],
   output logic              s_arready [NUM_MASTERS],
   output axil_data_t        s_rdata   [NUM_MASTERS],
   output logic [1:0]        s_rresp   [NUM_MASTERS],
   output logic              s_rvalid  [NUM_MASTERS],
   input  logic              s_rready  [NUM_MASTERS],
   input  axil_addr_t        s_awaddr  [NUM_MASTERS],
   input  logic              s_awvalid [NUM_MASTERS],
   output logic              s_awready [NUM_MASTERS],
   input  axil_data_t        s_wdata   [NUM_MASTERS],
   input  logic [STRB_W-1:0] s_wstrb   [NUM_MASTERS],
   input  logic              s_wvalid  [NUM_MASTERS],
   output logic              s_wready  [NUM_MASTERS],
   output logic [1:0]        s_bresp   [NUM_MASTERS],
   output logic              s_bvalid  [NUM_MASTERS],
   input  logic              s_bready  [NUM_MASTERS],

   output axil_addr_t        m_araddr,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  axil_data_t        m_rdata,
   input  logic [1:0]        m_rresp,
   input  logic              m_rvalid,
   output logic              m_rready,
   output axil_addr_t        m_awaddr,
   output logic              m_awvalid,
   input  logic              m_awready,
   output axil_data_t        m_wdata,
   output logic [STRB_W-1:0] m_wstrb,
   output logic              m_wvalid,
   input  logic              m_wready,
   input  logic [1:0]        m_bresp,
   input  logic              m_bvalid,
   output logic              m_bready
);

   import vga_axil_pkg::*;

   localparam int IDX_W = $clog2(NUM_MASTERS);

   axil_arb_state_e  r_state;
   logic [IDX_W-1:0] r_grant_idx;
   logic [IDX_W-1:0] r_rr_ptr;
   logic             r_aw_done;
   logic             r_w_done;

   logic             w_req [NUM_MASTERS];
   logic [IDX_W-1:0] w_gnt_idx;
   logic             w_gnt_valid;
   logic [IDX_W-1:0] w_next_ptr;
   logic             w_aw_hs;
   logic             w_w_hs;

   for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_req
      assign w_req[gi] = s_arvalid[gi] | s_awvalid[gi];
   end

   vga_rr_arbiter #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req       (w_req),
      .ptr       (r_rr_ptr),
      .gnt_idx   (w_gnt_idx),
      .gnt_valid (w_gnt_valid)
   );

   assign w_next_ptr = (w_gnt_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_gnt_idx + 1'b1;
   assign w_aw_hs    = m_awvalid & m_awready;
   assign w_w_hs     = m_wvalid & m_wready;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state     <= IDLE;
         r_grant_idx <= '0;
         r_rr_ptr    <= '0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt_valid) begin
                  r_grant_idx <= w_gnt_idx;
                  r_rr_ptr    <= w_next_ptr;
                  // A master holding both valids is served its write first
                  if (s_awvalid[w_gnt_idx]) begin
                     r_state   <= WR_REQ;
                     r_aw_done <= 1'b0;
                     r_w_done  <= 1'b0;
                  end else begin
                     r_state <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               if (m_arvalid && m_arready) begin
                  r_state <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (m_rvalid && m_rready) begin
                  r_state <= IDLE;
               end
            end
            WR_REQ: begin
               if (w_aw_hs) begin
                  r_aw_done <= 1'b1;
               end
               if (w_w_hs) begin
                  r_w_done <= 1'b1;
               end
               if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                  r_state <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (m_bvalid && m_bready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      m_araddr  = '0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      m_awaddr  = '0;
      m_awvalid = 1'b0;
      m_wdata   = '0;
      m_wstrb   = '0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         s_arready[i] = 1'b0;
         s_rdata[i]   = '0;
         s_rresp[i]   = '0;
         s_rvalid[i]  = 1'b0;
         s_awready[i] = 1'b0;
         s_wready[i]  = 1'b0;
         s_bresp[i]   = '0;
         s_bvalid[i]  = 1'b0;
      end

      // Payloads follow the frozen grant for the whole transaction
      if (r_state != IDLE) begin
         m_araddr = s_araddr[r_grant_idx];
         m_awaddr = s_awaddr[r_grant_idx];
         m_wdata  = s_wdata[r_grant_idx];
         m_wstrb  = s_wstrb[r_grant_idx];
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant_idx == IDX_W'(i)) begin
               s_rdata[i] = m_rdata;
               s_rresp[i] = m_rresp;
               s_bresp[i] = m_bresp;
               case (r_state)
                  RD_ADDR: s_arready[i] = m_arready;
                  RD_DATA: s_rvalid[i]  = m_rvalid;
                  WR_REQ: begin
                     s_awready[i] = m_awready & ~r_aw_done;
                     s_wready[i]  = m_wready & ~r_w_done;
                  end
                  WR_RESP: s_bvalid[i] = m_bvalid;
                  default: ;
               endcase
            end
         end
      end

      case (r_state)
         RD_ADDR: m_arvalid = s_arvalid[r_grant_idx];
         RD_DATA: m_rready  = s_rready[r_grant_idx];
         WR_REQ: begin
            m_awvalid = s_awvalid[r_grant_idx] & ~r_aw_done;
            m_wvalid  = s_wvalid[r_grant_idx] & ~r_w_done;
         end
         WR_RESP: m_bready = s_bready[r_grant_idx];
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_axil_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_axil_arbiter
//  Description : Directed self-checking bench for vga_axil_arbiter, two masters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_axil_arbiter;

   logic        clk;
   logic        arst_n;

   logic [31:0] s_araddr  [2];
   logic        s_arvalid [2];
   logic        s_arready [2];
   logic [31:0] s_rdata   [2];
   logic [1:0]  s_rresp   [2];
   logic        s_rvalid  [2];
   logic        s_rready  [2];
   logic [31:0] s_awaddr  [2];
   logic        s_awvalid [2];
   logic        s_awready [2];
   logic [31:0] s_wdata   [2];
   logic [3:0]  s_wstrb   [2];
   logic        s_wvalid  [2];
   logic        s_wready  [2];
   logic [1:0]  s_bresp   [2];
   logic        s_bvalid  [2];
   logic        s_bready  [2];

   logic [31:0] m_araddr;
   logic        m_arvalid, m_arready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rvalid, m_rready;
   logic [31:0] m_awaddr;
   logic        m_awvalid, m_awready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wvalid, m_wready;
   logic [1:0]  m_bresp;
   logic        m_bvalid, m_bready;

   int checks   = 0;
   int failures = 0;
   int ar_hs    = 0;
   int r_hs     = 0;
   int aw_hs    = 0;
   int w_hs     = 0;
   int b_hs     = 0;

   vga_axil_arbiter dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .s_araddr  (s_araddr),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .s_rdata   (s_rdata),
      .s_rresp   (s_rresp),
      .s_rvalid  (s_rvalid),
      .s_rready  (s_rready),
      .s_awaddr  (s_awaddr),
      .s_awvalid (s_awvalid),
      .s_awready (s_awready),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_wvalid  (s_wvalid),
      .s_wready  (s_wready),
      .s_bresp   (s_bresp),
      .s_bvalid  (s_bvalid),
      .s_bready  (s_bready),
      .m_araddr  (m_araddr),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_rdata   (m_rdata),
      .m_rresp   (m_rresp),
      .m_rvalid  (m_rvalid),
      .m_rready  (m_rready),
      .m_awaddr  (m_awaddr),
      .m_awvalid (m_awvalid),
      .m_awready (m_awready),
      .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),
      .m_wvalid  (m_wvalid),
      .m_wready  (m_wready),
      .m_bresp   (m_bresp),
      .m_bvalid  (m_bvalid),
      .m_bready  (m_bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream handshake counters
   always @(posedge clk) begin
      if (m_arvalid && m_arready) ar_hs <= ar_hs + 1;
      if (m_rvalid  && m_rready)  r_hs  <= r_hs + 1;
      if (m_awvalid && m_awready) aw_hs <= aw_hs + 1;
      if (m_wvalid  && m_wready)  w_hs  <= w_hs + 1;
      if (m_bvalid  && m_bready)  b_hs  <= b_hs + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input string what,
                      input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
      end
   endtask

   // Serves one read for master m, which must already be requesting in IDLE
   task automatic serve_read(input int m, input logic [31:0] addr,
                             input logic [31:0] data, input logic [1:0] resp,
                             input int arwait, input int rwait, input int rrdelay,
                             input string tag);
      int ar0, r0, o;
      ar0 = ar_hs;
      r0  = r_hs;
      o   = 1 - m;
      m_arready = 1'b0;
      tick();
      chk(tag, "m_arvalid", m_arvalid, 1);
      for (int k = 0; k < arwait; k++) begin
         chk(tag, "m_araddr_hold", m_araddr, addr);
         chk(tag, "s_arready_hold", s_arready[m], 0);
         tick();
      end
      m_arready = 1'b1;
      settle();
      chk(tag, "m_araddr", m_araddr, addr);
      chk(tag, "s_arready_gnt", s_arready[m], 1);
      chk(tag, "s_arready_other", s_arready[o], 0);
      tick();
      m_arready = 1'b0;
      chk(tag, "m_arvalid_after", m_arvalid, 0);
      repeat (rwait) tick();
      m_rvalid = 1'b1;
      m_rdata  = data;
      m_rresp  = resp;
      if (rrdelay > 0) begin
         s_rready[m] = 1'b0;
         settle();
         for (int k = 0; k < rrdelay; k++) begin
            chk(tag, "s_rdata_hold", s_rdata[m], data);
            chk(tag, "s_rresp_hold", s_rresp[m], resp);
            chk(tag, "m_rready_low", m_rready, 0);
            tick();
         end
         s_rready[m] = 1'b1;
      end
      settle();
      chk(tag, "s_rvalid", s_rvalid[m], 1);
      chk(tag, "s_rdata", s_rdata[m], data);
      chk(tag, "s_rresp", s_rresp[m], resp);
      chk(tag, "s_rvalid_other", s_rvalid[o], 0);
      chk(tag, "m_rready", m_rready, 1);
      tick();
      m_rvalid = 1'b0;
      m_rdata  = '0;
      m_rresp  = '0;
      chk(tag, "ar_handshakes", ar_hs - ar0, 1);
      chk(tag, "r_handshakes", r_hs - r0, 1);
   endtask

   initial begin
      int aw0, w0, b0;
      arst_n    = 1'b0;
      m_arready = 1'b0;
      m_rdata   = '0;
      m_rresp   = '0;
      m_rvalid  = 1'b0;
      m_awready = 1'b0;
      m_wready  = 1'b0;
      m_bresp   = '0;
      m_bvalid  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_araddr[i]  = '0;
         s_arvalid[i] = 1'b0;
         s_rready[i]  = 1'b1;
         s_awaddr[i]  = '0;
         s_awvalid[i] = 1'b0;
         s_wdata[i]   = '0;
         s_wstrb[i]   = '0;
         s_wvalid[i]  = 1'b0;
         s_bready[i]  = 1'b1;
      end

      // Reset state
      #3;
      chk("rst", "m_arvalid", m_arvalid, 0);
      chk("rst", "m_awvalid", m_awvalid, 0);
      chk("rst", "m_wvalid", m_wvalid, 0);
      chk("rst", "m_rready", m_rready, 0);
      chk("rst", "m_bready", m_bready, 0);
      chk("rst", "s_arready0", s_arready[0], 0);
      chk("rst", "m_araddr", m_araddr, 0);
      tick();
      tick();
      arst_n = 1'b1;

      // Single read with two slave wait cycles
      s_araddr[0]  = 32'h10;
      s_arvalid[0] = 1'b1;
      serve_read(0, 32'h10, 32'hDEADBEEF, 2'b00, 0, 2, 0, "single");
      s_arvalid[0] = 1'b0;
      settle();
      chk("single", "s_rdata_idle", s_rdata[0], 0);

      // Contention from a fresh reset: m0, m1, m0, m1
      arst_n = 1'b0;
      #1;
      arst_n = 1'b1;
      s_araddr[0]  = 32'h100;
      s_araddr[1]  = 32'h200;
      s_arvalid[0] = 1'b1;
      s_arvalid[1] = 1'b1;
      serve_read(0, 32'h100, 32'hA0A0_0001, 2'b00, 0, 0, 0, "cont0");
      serve_read(1, 32'h200, 32'hB0B0_0002, 2'b00, 0, 0, 0, "cont1");
      serve_read(0, 32'h100, 32'hA0A0_0003, 2'b00, 0, 0, 0, "cont2");
      serve_read(1, 32'h200, 32'hB0B0_0004, 2'b00, 0, 0, 0, "cont3");
      s_arvalid[0] = 1'b0;
      s_arvalid[1] = 1'b0;

      // Write by m1 with W presented two cycles ahead of AW
      aw0 = aw_hs;
      w0  = w_hs;
      b0  = b_hs;
      s_wdata[1]  = 32'h12345678;
      s_wstrb[1]  = 4'hF;
      s_wvalid[1] = 1'b1;
      tick();
      tick();
      chk("wr", "m_wvalid_idle", m_wvalid, 0);
      s_awaddr[1]  = 32'h4;
      s_awvalid[1] = 1'b1;
      m_wready     = 1'b1;
      m_awready    = 1'b0;
      tick();
      chk("wr", "m_awvalid", m_awvalid, 1);
      chk("wr", "m_awaddr", m_awaddr, 32'h4);
      chk("wr", "m_wvalid", m_wvalid, 1);
      chk("wr", "m_wdata", m_wdata, 32'h12345678);
      chk("wr", "m_wstrb", m_wstrb, 4'hF);
      chk("wr", "s_wready1", s_wready[1], 1);
      chk("wr", "s_awready1", s_awready[1], 0);
      chk("wr", "s_wready0", s_wready[0], 0);
      tick();
      chk("wr", "m_wvalid_done", m_wvalid, 0);
      chk("wr", "s_wready_done", s_wready[1], 0);
      m_awready = 1'b1;
      settle();
      chk("wr", "s_awready_late", s_awready[1], 1);
      tick();
      s_awvalid[1] = 1'b0;
      s_wvalid[1]  = 1'b0;
      m_awready    = 1'b0;
      m_wready     = 1'b0;
      chk("wr", "aw_handshakes", aw_hs - aw0, 1);
      chk("wr", "w_handshakes", w_hs - w0, 1);
      chk("wr", "m_awvalid_resp", m_awvalid, 0);
      m_bvalid = 1'b1;
      m_bresp  = 2'b00;
      settle();
      chk("wr", "s_bvalid1", s_bvalid[1], 1);
      chk("wr", "s_bresp1", s_bresp[1], 2'b00);
      chk("wr", "s_bvalid0", s_bvalid[0], 0);
      chk("wr", "m_bready", m_bready, 1);
      tick();
      m_bvalid = 1'b0;
      settle();
      chk("wr", "s_bvalid_idle", s_bvalid[1], 0);
      chk("wr", "b_handshakes", b_hs - b0, 1);

      // Backpressure on AR (5 cycles) and R (3 cycles)
      s_araddr[0]  = 32'h30;
      s_arvalid[0] = 1'b1;
      serve_read(0, 32'h30, 32'hCAFEF00D, 2'b00, 5, 1, 3, "bp");
      s_arvalid[0] = 1'b0;

      // m0 holds both AW/W and AR; write goes first and gets SLVERR
      s_awaddr[0]  = 32'h8;
      s_awvalid[0] = 1'b1;
      s_wdata[0]   = 32'hA5A5A5A5;
      s_wstrb[0]   = 4'hF;
      s_wvalid[0]  = 1'b1;
      s_araddr[0]  = 32'h0C;
      s_arvalid[0] = 1'b1;
      m_awready    = 1'b1;
      m_wready     = 1'b1;
      tick();
      chk("err", "m_awvalid", m_awvalid, 1);
      chk("err", "m_wvalid", m_wvalid, 1);
      chk("err", "m_arvalid", m_arvalid, 0);
      chk("err", "m_wdata", m_wdata, 32'hA5A5A5A5);
      tick();
      s_awvalid[0] = 1'b0;
      s_wvalid[0]  = 1'b0;
      m_awready    = 1'b0;
      m_wready     = 1'b0;
      m_bvalid     = 1'b1;
      m_bresp      = 2'b10;
      settle();
      chk("err", "s_bvalid0", s_bvalid[0], 1);
      chk("err", "s_bresp0", s_bresp[0], 2'b10);
      chk("err", "s_arready0", s_arready[0], 0);
      tick();
      m_bvalid = 1'b0;
      m_bresp  = 2'b00;
      serve_read(0, 32'h0C, 32'h11112222, 2'b00, 0, 0, 0, "err_rd");
      s_arvalid[0] = 1'b0;

      // Reset while in WR_RESP, then m0 regains priority
      s_awaddr[0]  = 32'h14;
      s_awvalid[0] = 1'b1;
      s_wdata[0]   = 32'h55AA55AA;
      s_wvalid[0]  = 1'b1;
      m_awready    = 1'b1;
      m_wready     = 1'b1;
      tick();
      tick();
      s_awvalid[0] = 1'b0;
      s_wvalid[0]  = 1'b0;
      m_awready    = 1'b0;
      m_wready     = 1'b0;
      m_bvalid     = 1'b1;
      m_bresp      = 2'b10;
      settle();
      chk("rstmid", "s_bvalid_pre", s_bvalid[0], 1);
      arst_n = 1'b0;
      #1;
      chk("rstmid", "s_bvalid0", s_bvalid[0], 0);
      chk("rstmid", "s_bresp0", s_bresp[0], 0);
      chk("rstmid", "m_bready", m_bready, 0);
      chk("rstmid", "m_awaddr", m_awaddr, 0);
      chk("rstmid", "m_wdata", m_wdata, 0);
      m_bvalid = 1'b0;
      m_bresp  = 2'b00;
      #1;
      arst_n = 1'b1;
      s_araddr[0]  = 32'h40;
      s_araddr[1]  = 32'h44;
      s_arvalid[0] = 1'b1;
      s_arvalid[1] = 1'b1;
      serve_read(0, 32'h40, 32'h0BADF00D, 2'b00, 0, 0, 0, "post_rst0");
      s_arvalid[0] = 1'b0;
      serve_read(1, 32'h44, 32'h87654321, 2'b00, 0, 1, 0, "post_rst1");
      s_arvalid[1] = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_axil_arbiter.md
# vga_axil_arbiter

Round-robin AXI-Lite arbiter that shares one downstream AXI-Lite slave (the VGA register block) between `NUM_MASTERS` upstream masters. It serializes traffic with at most one outstanding transaction (read or write) on the downstream port. Upstream and downstream channels follow the team AXI-Lite signal set: AR/R/AW/W/B, full-word `wstrb` only. It sits between the CPU/debug masters and the VGA control registers.

## Interface

**Parameters**
- `NUM_MASTERS`, default 2: number of upstream masters, ≥ 2.
- `axil_addr_t`, default `vga_axil_pkg::axil_addr_t`: address type.
- `axil_data_t`, default `vga_axil_pkg::axil_data_t`: data type. Strobe width is `$bits(axil_data_t)/8`.

**Ports.** Clock and reset:
- `clk` in 1: clock.
- `arst_n` in 1: reset, asynchronous, active-low.

Upstream ports use the `s_` prefix. Each is a `[NUM_MASTERS]` array, indexed by master.
- `s_araddr`, `s_arvalid` in; `s_arready` out: AR.
- `s_rdata`, `s_rresp`, `s_rvalid` out; `s_rready` in: R.
- `s_awaddr`, `s_awvalid` in; `s_awready` out: AW.
- `s_wdata`, `s_wstrb`, `s_wvalid` in; `s_wready` out: W.
- `s_bresp`, `s_bvalid` out; `s_bready` in: B.

Downstream ports use the `m_` prefix. They are single-instance with the same widths and reversed directions: `m_araddr/arvalid/arready`, `m_rdata/rresp/rvalid/rready`, `m_awaddr/awvalid/awready`, `m_wdata/wstrb/wvalid/wready`, `m_bresp/bvalid/bready`.

## Operation

**FSM states:** `IDLE`, `RD_ADDR`, `RD_DATA`, `WR_REQ`, `WR_RESP`. Registers: `grant_idx`, `rr_ptr`, `aw_done`, `w_done`.

**IDLE**
- A master requests when `s_arvalid[i] | s_awvalid[i]`.
- The winner is the first requester at or after `rr_ptr`, searching circularly.
- Register `grant_idx` and set `rr_ptr <= winner+1`, modulo `NUM_MASTERS`.
- If the winner asserts both valids, the write wins; its read waits for a later grant.
- Next state is `WR_REQ` (clearing `aw_done`/`w_done`) or `RD_ADDR`.

**RD_ADDR**
- `m_ar*` is combinationally muxed from `grant_idx`.
- `s_arready[grant_idx] = m_arready`.
- On handshake, go to `RD_DATA`.

**RD_DATA**
- `m_r*` is routed to `grant_idx`.
- `m_rready = s_rready[grant_idx]`.
- On handshake, go to `IDLE`.

**WR_REQ**
- AW and W are forwarded independently.
- `m_awvalid = s_awvalid[g] & ~aw_done`. `m_wvalid = s_wvalid[g] & ~w_done`. Each `s_*ready` is gated the same way.
- Set the matching `*_done` on each handshake.
- Go to `WR_RESP` once both handshakes have occurred (registered or in the current cycle).

**WR_RESP**
- B is routed to `grant_idx`.
- On handshake, go to `IDLE`.

**General rules**
- Non-granted masters see all `s_*ready` = 0 and `s_rvalid`/`s_bvalid` = 0.
- Downstream valids are 0 in every state except their own phase.
- Data, address and resp outputs carry the muxed value regardless of valid, and are 0 in `IDLE`.
- Responses (`OKAY`, `SLVERR`, ...) pass through unmodified.
- `s_wstrb` passes through. Only `'1` is legal.
- A master dropping valid before handshake is a protocol violation. The arbiter does not recover from it.

## Timing

**Reset**
- State `IDLE`, `rr_ptr`=0, `grant_idx`=0, `aw_done`=`w_done`=0.
- All valid and ready outputs are 0, and all data/addr/resp outputs are 0.
- Reset mid-transaction abandons it immediately. The downstream slave shares the reset.

**Latency**
- Arbitration: 1 cycle. A request seen in `IDLE` at edge N presents `m_arvalid`/`m_awvalid` from edge N+1.
- Back-to-back: one `IDLE` cycle between transactions. Minimum read is 3 cycles for a zero-wait slave.

**Stability and paths**
- While valid and not ready, muxed outputs are stable, because `grant_idx` is frozen outside `IDLE`.
- No combinational path from `m_*ready` to any `m_*valid`.
- Combinational paths exist only for valid→valid, ready→ready and data→data through the mux.

## Structure

- `vga_axil_pkg` gains:
  - `axil_arb_state_e`, the FSM enum.
  - `AXIL_RESP_OKAY`/`SLVERR` constants, if not already present.
- Sub-module `vga_rr_arbiter` is parameterized by `N`. It takes inputs `req[N]` and `ptr` and produces outputs `gnt_idx` and `gnt_valid`, as pure combinational next-grant logic.
- The top holds the FSM and the muxes.

## Test plan

- **Single read:** m0 reads 0x10, slave returns 0xDEADBEEF/OKAY after 2 wait cycles → m0 gets 0xDEADBEEF/OKAY; m1 sees no valid/ready.
- **Contention:** after reset, m0 and m1 read simultaneously and both re-request → grants go m0, m1, m0, m1; `m_araddr` matches each master.
- **Write ordering:** m1 writes 0x4←0x12345678 with W two cycles before AW → exactly one `m_wvalid` handshake and one `m_awvalid` handshake; `m_wdata`=0x12345678; m1 gets B OKAY.
- **Backpressure:** slave holds `m_arready`=0 for 5 cycles, and `s_rready`=0 for 3 cycles after `rvalid` → `m_araddr` and the routed `rdata`/`rresp` stay stable; no lost or duplicated handshake.
- **Error and both-valid:** slave returns SLVERR to m0's write while m0 also holds `arvalid` → m0 gets `bresp`=SLVERR, and its read is then served on a later grant.
- **Reset mid-transaction:** assert `arst_n`=0 in `WR_RESP` → all outputs 0 in the same cycle; after release, a new m1 read completes normally with m0 having priority.
